serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial WIDTH-bit subtractor with borrow-in and borrow-out.
- It is the inverse-operation counterpart of the team's combinational ripple adder, and is built for area-constrained datapaths.
- It accepts one operand set over a valid/ready input handshake and resolves one bit per clock, LSB first.
- It presents {bout, diff} over a valid/ready output handshake.

Parameters:
- WIDTH, 4, operand and difference width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand set on a/b/bin is valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout/ovf hold a completed result.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 iff a < b + bin.
- busy  output  1  high in RUN or DONE.
- ovf  output  1  signed overflow flag (see Optional Feature).

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (rst_n low at a clk edge): state goes to IDLE; in_ready=1; out_valid=0; busy=0; diff=0; bout=0; ovf=0; bit counter=0.
- Reset applied mid-RUN or mid-DONE aborts the operation and discards the result. No partial result is ever presented.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b, bin into internal shift registers, load borrow=bin, clear counter, go to RUN.
- RUN:
  - in_ready=0; operand inputs are ignored.
  - Each edge processes bit i=counter: d_i = a_i ^ b_i ^ borrow; borrow_next = (~a_i & b_i) | (~(a_i ^ b_i) & borrow).
  - d_i is shifted into the diff register MSB-first, so that after WIDTH shifts bit i sits at position i.
  - After exactly WIDTH RUN edges, go to DONE with bout=final borrow.
- Latency: the acceptance edge is E. out_valid rises after edge E+WIDTH, so WIDTH+1 edges from acceptance to a visible result.
- DONE:
  - out_valid=1; diff, bout and ovf are stable and unchanged while out_ready=0.
  - On an edge with out_ready=1: go to IDLE, drop out_valid, raise in_ready.
- diff/bout/ovf hold their last values in IDLE. Only out_valid qualifies them.
- No overlap: a new operand is never accepted in the same edge as result handoff. The minimum issue interval is WIDTH+2 cycles.
- in_valid held while in_ready=0 has no effect. The source must hold in_valid until it is accepted.
- Width rule: {bout, diff} equals the low WIDTH+1 bits of the two's-complement result of a - b - bin.
- Wrap-around: a=0, b=0, bin=1 gives all-ones diff with bout=1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - ovf is registered at the DONE transition.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), treating a and b as signed.
  - bin participates in diff as normal.
- Undefined:
  - ovf is tied to 0 and no overflow logic is synthesized.
  - The port is still present so instantiations are unchanged.

Test Plan:
- Basic subtraction, WIDTH=4: a=5, b=3, bin=0 -> after WIDTH+1 edges out_valid=1, diff=4'b0010, bout=0.
- Borrow case: a=3, b=5, bin=0 -> diff=4'b1110, bout=1. With a=0, b=0, bin=1 -> diff=4'b1111, bout=1. With a=15, b=15, bin=1 -> diff=4'b1111, bout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1, diff/bout stable, in_ready=0. Pulsing in_valid with new operands is ignored. Raising out_ready -> IDLE next edge, in_ready=1.
- Reset mid-operation: assert rst_n=0 for one edge at RUN bit 2 -> next cycle IDLE, out_valid=0, diff=0, bout=0. A following a=9, b=4 -> diff=5, bout=0.
- Overflow (macro defined): a=8, b=1, bin=0 -> diff=7, ovf=1. a=7, b=15 -> diff=8, ovf=1. a=6, b=2 -> ovf=0. With the macro undefined, ovf=0 in all three cases.
- Exhaustive: all 512 combinations of a, b, bin with out_ready=1 -> {bout, diff} == 5-bit (a - b - bin) for every case; the bench reports any mismatch and the total count.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: resolves (a - b - bin) one bit per clock, LSB first, over valid/ready handshakes.
// Optional signed-overflow flag enabled with `define SERIAL_SUB_OVF_EN (ovf reads 0 otherwise).
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             d_bit;
    logic             borrow_nxt;
    logic             last_bit;

    function automatic logic sub_diff(input logic ai, input logic bi, input logic br);
        return ai ^ bi ^ br;
    endfunction

    function automatic logic sub_borrow(input logic ai, input logic bi, input logic br);
        return (~ai & bi) | (~(ai ^ bi) & br);
    endfunction

    assign d_bit      = sub_diff(a_q[0], b_q[0], borrow_q);
    assign borrow_nxt = sub_borrow(a_q[0], b_q[0], borrow_q);
    assign last_bit   = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Operands shift right so bit i is always at position 0.
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                res_d    = {d_bit, res_q[WIDTH-1:1]};
                borrow_d = borrow_nxt;
                cnt_d    = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d = S_DONE;
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
                    // On the last bit a_q[0]/b_q[0] are the operand sign bits and d_bit is the result sign.
                    ovf_d   = (a_q[0] != b_q[0]) && (d_bit != a_q[0]);
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Working registers are always loaded on acceptance before use, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        res_q    <= res_d;
        borrow_q <= borrow_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed, exhaustive and randomized operand sets vs an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         ovf;

    int n_vec = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {bout, diff} is the low W+1 bits of the integer a - b - bin.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        int r;
        r = int'(av) - int'(bv) - int'(bi);
        return (W+1)'(r);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
`ifdef SERIAL_SUB_OVF_EN
        logic [W:0] r;
        r = ref_sub(av, bv, bi);
        return (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
`else
        return 1'b0 & (av[0] ^ bv[0] ^ bi);
`endif
    endfunction

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input int stall);
        logic [W:0] exp;
        logic       exp_ovf;
        int         n;
        exp     = ref_sub(av, bv, bi);
        exp_ovf = ref_ovf(av, bv, bi);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a         = av;
        b         = bv;
        bin       = bi;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom);
        n = 0;
        while (!out_valid && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(W));
        check("diff", 32'(diff), 32'(exp[W-1:0]));
        check("bout", 32'(bout), 32'(exp[W]));
        check("ovf", 32'(ovf), 32'(exp_ovf));
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_diff", 32'(diff), 32'(exp[W-1:0]));
            check("stall_bout", 32'(bout), 32'(exp[W]));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        // in_valid stays high across the handoff edge; it must not be taken there.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("handoff_valid", 32'(out_valid), 32'd0);
        check("handoff_in_ready", 32'(in_ready), 32'd1);
        check("hold_diff", 32'(diff), 32'(exp[W-1:0]));
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        do_op(4'd5, 4'd3, 1'b0, 0);
        do_op(4'd3, 4'd5, 1'b0, 0);
        do_op(4'd0, 4'd0, 1'b1, 0);
        do_op(4'd15, 4'd15, 1'b1, 0);
        do_op(4'd5, 4'd3, 1'b0, 3);
        do_op(4'd8, 4'd1, 1'b0, 0);
        do_op(4'd7, 4'd15, 1'b0, 0);
        do_op(4'd6, 4'd2, 1'b0, 0);

        // Abort mid-RUN: reset lands on the edge that would process bit 2.
        @(negedge clk);
        a        = 4'd3;
        b        = 4'd5;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("run_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        repeat (W + 2) begin
            @(negedge clk);
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        do_op(4'd9, 4'd4, 1'b0, 0);

        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int bi = 0; bi < 2; bi++)
                    do_op(W'(av), W'(bv), 1'(bi), 0);

        repeat (40) do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
